uart_print_ctrl: RTL

- Drains the 8-bit read side of the camera-data FIFO (FIFO_HS, non-show-ahead) and serialises each byte onto the board UART TX pin as 8N1.
- On every frame-start pulse, inserts a 2-byte sync header so the host can re-align to frame boundaries.
- Reports payload byte counts per frame for debug/PMOD.
- Runs in the FIFO read-clock domain (the FIFO RdClk is driven by this block's clock).

---
 rtl/uart_print_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_print_ctrl.sv
// uart_print_ctrl: drains camera FIFO bytes onto an 8N1 UART line, inserting a sync header per frame
module uart_print_ctrl #(
  parameter int CLK_FREQ = 27_000_000,
  parameter int BAUD = 115_200,
  parameter logic [15:0] SYNC_WORD = 16'hAA55
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_enable,
  input  logic        I_frame_start,
  input  logic        I_fifo_empty,
  input  logic [7:0]  I_fifo_q,
  output logic        O_fifo_rd_en,
  output logic        O_uart_tx,
  output logic        O_busy,
  output logic [23:0] O_frame_bytes,
  output logic [23:0] O_last_frame_bytes,
  output logic        O_sof_overrun
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;
  typedef enum logic [1:0] {SRC_PAY, SRC_HDR0, SRC_HDR1} src_t;
  state_t state, state_nx;
  src_t src, src_nx;
  logic hdr_pending, hdr1_pending, tx, sof_overrun;
  logic [CW-1:0] baud_cnt;
  logic [3:0] bit_idx;
  logic [8:0] shreg;
  logic [23:0] frame_bytes, last_frame_bytes;
  logic hdr0_load, hdr1_load, pay_load, bit_end, byte_end;
  logic [7:0] load_byte;
  assign hdr0_load = state == LOAD && src == SRC_HDR0;
  assign hdr1_load = state == LOAD && src == SRC_HDR1;
  assign pay_load = state == LOAD && src == SRC_PAY;
  assign bit_end = state == SHIFT && baud_cnt == CNT_MAX;
  assign byte_end = bit_end && bit_idx == 4'd9;
  assign load_byte = src == SRC_PAY ? I_fifo_q : src == SRC_HDR0 ? SYNC_WORD[15:8] : SYNC_WORD[7:0];
  assign O_fifo_rd_en = state == FETCH;
  assign O_busy = state != IDLE;
  assign O_uart_tx = tx;
  assign O_frame_bytes = frame_bytes;
  assign O_last_frame_bytes = last_frame_bytes;
  assign O_sof_overrun = sof_overrun;
  always_comb begin
    state_nx = state;
    src_nx = src;
    case (state)
      IDLE: begin
        if (I_enable && hdr_pending) begin
          state_nx = LOAD;
          src_nx = SRC_HDR0;
        end else if (hdr1_pending) begin
          state_nx = LOAD;
          src_nx = SRC_HDR1;
        end else if (I_enable && !I_fifo_empty) begin
          state_nx = FETCH;
          src_nx = SRC_PAY;
        end
      end
      FETCH: state_nx = LOAD;
      LOAD: state_nx = SHIFT;
      SHIFT: state_nx = byte_end ? IDLE : SHIFT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= IDLE;
      src <= SRC_PAY;
      hdr_pending <= 1'b0;
      hdr1_pending <= 1'b0;
      sof_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      src <= src_nx;
      hdr_pending <= I_frame_start || (hdr_pending && !hdr0_load);
      hdr1_pending <= hdr0_load || (hdr1_pending && !hdr1_load);
      sof_overrun <= I_frame_start && hdr_pending && !hdr0_load;
    end
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      tx <= 1'b1;
      shreg <= '1;
      baud_cnt <= '0;
      bit_idx <= '0;
    end else if (state == LOAD) begin
      tx <= 1'b0;
      shreg <= {1'b1, load_byte};
      baud_cnt <= '0;
      bit_idx <= '0;
    end else if (state == SHIFT) begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      if (bit_end) begin
        tx <= byte_end ? 1'b1 : shreg[0];
        shreg <= {1'b1, shreg[8:1]};
        bit_idx <= bit_idx + 4'd1;
      end
    end
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      frame_bytes <= '0;
      last_frame_bytes <= '0;
    end else if (hdr0_load) begin
      last_frame_bytes <= frame_bytes;
      frame_bytes <= '0;
    end else if (pay_load && frame_bytes != '1) begin
      frame_bytes <= frame_bytes + 24'd1;
    end
  end
endmodule
